// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and helpers for the LED pattern engine.
package led_pattern_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_OFF     = 3'd0;
  localparam mode_t MODE_ON      = 3'd1;
  localparam mode_t MODE_BLINK   = 3'd2;
  localparam mode_t MODE_PWM     = 3'd3;
  localparam mode_t MODE_BREATHE = 3'd4;
  localparam mode_t MODE_COUNT   = 3'd5;

  function automatic logic mode_legal(input mode_t mode);
    return mode <= MODE_COUNT;
  endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Channel configuration write port: valid/ready request plus reject pulse.
interface led_pattern_engine_if #(
  parameter int unsigned CH_W     = 3,
  parameter int unsigned PWM_BITS = 8
);
  import led_pattern_pkg::*;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  mode_t               cfg_mode;
  logic [PWM_BITS-1:0] cfg_arg;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_arg,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_arg,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: holds mode/arg and blink/breathe state, produces the next LED value.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_27m,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_cnt_bit,
  input  logic                i_wr,
  input  mode_t               i_mode,
  input  logic [PWM_BITS-1:0] i_arg,
  output logic                o_led_nxt
);

  localparam logic [PWM_BITS-1:0] LevelMax = '1;

  mode_t               r_mode,   w_mode;
  logic [PWM_BITS-1:0] r_arg,    w_arg;
  logic [PWM_BITS-1:0] r_phase,  w_phase;
  logic [PWM_BITS-1:0] r_level,  w_level;
  logic                r_dir_dn, w_dir_dn;
  logic                r_blink,  w_blink;
  logic                w_wrap;

  assign w_wrap = (r_phase == r_arg);

  always_comb begin
    w_mode   = r_mode;
    w_arg    = r_arg;
    w_phase  = r_phase;
    w_level  = r_level;
    w_dir_dn = r_dir_dn;
    w_blink  = r_blink;
    // A write in the same cycle as a tick wins; the tick is dropped for this channel.
    if (i_wr) begin
      w_mode   = i_mode;
      w_arg    = i_arg;
      w_phase  = '0;
      w_level  = '0;
      w_dir_dn = 1'b0;
      w_blink  = 1'b0;
    end else if (i_tick) begin
      w_phase = w_wrap ? '0 : r_phase + 1'b1;
      if (w_wrap && r_mode == MODE_BLINK) begin
        w_blink = ~r_blink;
      end
      if (w_wrap && r_mode == MODE_BREATHE) begin
        if (!r_dir_dn) begin
          if (r_level == LevelMax) begin
            w_dir_dn = 1'b1;
            w_level  = r_level - 1'b1;
          end else begin
            w_level  = r_level + 1'b1;
          end
        end else if (r_level == '0) begin
          w_dir_dn = 1'b0;
        end else begin
          w_level  = r_level - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= MODE_OFF;
      r_arg    <= '0;
      r_phase  <= '0;
      r_level  <= '0;
      r_dir_dn <= 1'b0;
      r_blink  <= 1'b0;
    end else begin
      r_mode   <= w_mode;
      r_arg    <= w_arg;
      r_phase  <= w_phase;
      r_level  <= w_level;
      r_dir_dn <= w_dir_dn;
      r_blink  <= w_blink;
    end
  end

  always_comb begin
    o_led_nxt = 1'b0;
    case (r_mode)
      MODE_ON:      o_led_nxt = 1'b1;
      MODE_BLINK:   o_led_nxt = r_blink;
      MODE_PWM:     o_led_nxt = (i_pwm_cnt < r_arg);
      MODE_BREATHE: o_led_nxt = (i_pwm_cnt < r_level);
      MODE_COUNT:   o_led_nxt = i_cnt_bit;
      default:      o_led_nxt = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-channel LED driver: shared tick prescaler, PWM and binary counters, config handshake,
// per-channel pattern generators and a registered LED output.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 27000000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned N_LED      = 6,
  parameter int unsigned PWM_BITS   = 8
) (
  input  logic                 clk_27m,
  input  logic                 rst_n,
  led_pattern_engine_if.slave  cfg,
  output logic                 o_tick,
  output logic [N_LED-1:0]     o_led
);

  localparam int unsigned TICK_DIV = CLOCK_FREQ / TICK_HZ;
  localparam int unsigned PRESC_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CH_W     = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("led_pattern_engine: CLOCK_FREQ/TICK_HZ must be at least 2");
  end
  if (N_LED < 1 || N_LED > 16) begin : g_bad_n_led
    $error("led_pattern_engine: N_LED must be in 1..16");
  end
  if (PWM_BITS < 2 || PWM_BITS > 12) begin : g_bad_pwm_bits
    $error("led_pattern_engine: PWM_BITS must be in 2..12");
  end

  logic [PRESC_W-1:0]  r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [N_LED-1:0]    r_shared;
  logic                r_ready;
  logic                r_err;
  logic                r_wr_stb;
  logic [CH_W-1:0]     r_wr_ch;
  mode_t               r_wr_mode;
  logic [PWM_BITS-1:0] r_wr_arg;
  logic [N_LED-1:0]    r_led;

  logic                w_tick;
  logic                w_accept;
  logic                w_legal;
  logic [N_LED-1:0]    w_led_nxt;

  assign w_tick   = (r_presc == PrescLast);
  assign w_accept = cfg.cfg_valid && r_ready;
  assign w_legal  = mode_legal(cfg.cfg_mode) && (32'(cfg.cfg_ch) < N_LED);

  assign o_tick        = w_tick;
  assign o_led         = r_led;
  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_err   = r_err;

  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      r_shared  <= '0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + 1'b1;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_tick) begin
        r_shared <= r_shared + 1'b1;
      end
    end
  end

  // Accepted writes are captured here and committed to the channel on the following edge,
  // which is why ready drops for exactly one cycle after each accept.
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_ch   <= '0;
      r_wr_mode <= MODE_OFF;
      r_wr_arg  <= '0;
    end else begin
      r_ready  <= ~w_accept;
      r_err    <= w_accept && !w_legal;
      r_wr_stb <= w_accept && w_legal;
      if (w_accept) begin
        r_wr_ch   <= cfg.cfg_ch;
        r_wr_mode <= cfg.cfg_mode;
        r_wr_arg  <= cfg.cfg_arg;
      end
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_channel (
      .clk_27m   (clk_27m),
      .rst_n     (rst_n),
      .i_tick    (w_tick),
      .i_pwm_cnt (r_pwm_cnt),
      .i_cnt_bit (r_shared[i]),
      .i_wr      (r_wr_stb && (r_wr_ch == CH_W'(i))),
      .i_mode    (r_wr_mode),
      .i_arg     (r_wr_arg),
      .o_led_nxt (w_led_nxt[i])
    );
  end

  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed scenarios plus random config traffic, every cycle
// compared against a behavioural model of the channel rules.
module tb_led_pattern_engine;
  import led_pattern_pkg::*;

  localparam int N    = 6;
  localparam int PB   = 4;
  localparam int CHW  = 3;
  localparam int TDIV = 10;
  localparam int LMAX = (1 << PB) - 1;

  logic         clk_27m = 1'b0;
  logic         rst_n   = 1'b0;
  logic         tick;
  logic [N-1:0] led;

  led_pattern_engine_if #(.CH_W(CHW), .PWM_BITS(PB)) cfg_if ();

  led_pattern_engine #(
    .CLOCK_FREQ (100),
    .TICK_HZ    (10),
    .N_LED      (N),
    .PWM_BITS   (PB)
  ) dut (
    .clk_27m (clk_27m),
    .rst_n   (rst_n),
    .cfg     (cfg_if),
    .o_tick  (tick),
    .o_led   (led)
  );

  always #5 clk_27m = ~clk_27m;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_presc, m_pwm, m_shared, m_ready, m_err, m_accept, m_led;
  int m_pend, m_pch, m_pmode, m_parg;
  int m_mode[N], m_arg[N], m_phase[N], m_level[N], m_up[N], m_blink[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_pwm = 0; m_shared = 0; m_ready = 0; m_err = 0; m_accept = 0; m_led = 0;
    m_pend = 0; m_pch = 0; m_pmode = 0; m_parg = 0;
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0; m_arg[i] = 0; m_phase[i] = 0; m_level[i] = 0; m_up[i] = 1; m_blink[i] = 0;
    end
  endtask

  function automatic int ch_out(input int i);
    case (m_mode[i])
      1:       return 1;
      2:       return m_blink[i];
      3:       return (m_pwm < m_arg[i]) ? 1 : 0;
      4:       return (m_pwm < m_level[i]) ? 1 : 0;
      5:       return (m_shared >> i) & 1;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one rising edge, using the inputs currently driven.
  task automatic model_step();
    int nled, t, v, ch, md, acc, legal;
    nled = 0;
    for (int i = 0; i < N; i++) nled |= ch_out(i) << i;
    t = (m_presc == TDIV - 1) ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      if (m_pend != 0 && m_pch == i) begin
        m_mode[i] = m_pmode; m_arg[i] = m_parg;
        m_phase[i] = 0; m_level[i] = 0; m_up[i] = 1; m_blink[i] = 0;
      end else if (t != 0 && (m_mode[i] == 2 || m_mode[i] == 4)) begin
        if (m_phase[i] != m_arg[i]) begin
          m_phase[i]++;
        end else begin
          m_phase[i] = 0;
          if (m_mode[i] == 2) m_blink[i] ^= 1;
          else if (m_up[i] != 0) begin
            if (m_level[i] == LMAX) begin m_up[i] = 0; m_level[i]--; end
            else m_level[i]++;
          end else if (m_level[i] == 0) m_up[i] = 1;
          else m_level[i]--;
        end
      end
    end
    m_shared = (m_shared + t) % (1 << N);
    m_pwm    = (m_pwm + 1) % (1 << PB);
    m_presc  = (m_presc + 1) % TDIV;
    v  = cfg_if.cfg_valid ? 1 : 0;
    ch = int'(cfg_if.cfg_ch);
    md = int'(cfg_if.cfg_mode);
    acc   = (v != 0 && m_ready != 0) ? 1 : 0;
    legal = (ch < N && md <= 5) ? 1 : 0;
    m_accept = acc;
    m_pend   = acc & legal;
    if (acc != 0) begin m_pch = ch; m_pmode = md; m_parg = int'(cfg_if.cfg_arg); end
    m_err   = (acc != 0 && legal == 0) ? 1 : 0;
    m_ready = (acc == 0) ? 1 : 0;
    m_led   = nled;
  endtask

  task automatic cycle();
    @(posedge clk_27m);
    model_step();
    #1;
    check("tick", tick, (m_presc == TDIV - 1) ? 1 : 0);
    check("cfg_ready", cfg_if.cfg_ready, m_ready);
    check("cfg_err", cfg_if.cfg_err, m_err);
    check("led", led, m_led);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wr(input int ch, input int md, input int arg);
    for (int g = 0; g < 4 && m_ready == 0; g++) cycle();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CHW'(ch);
    cfg_if.cfg_mode  = mode_t'(md);
    cfg_if.cfg_arg   = PB'(arg);
    cycle();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic duty(input string tag, input int exp);
    int hi;
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      hi += led[0] ? 1 : 0;
    end
    check(tag, hi, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt, g;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_mode  = MODE_OFF;
    cfg_if.cfg_arg   = '0;
    model_reset();

    #12;
    check("rst_led", led, 0);
    check("rst_ready", cfg_if.cfg_ready, 0);
    check("rst_tick", tick, 0);
    check("rst_err", cfg_if.cfg_err, 0);
    #20;
    check("rst_ready_held", cfg_if.cfg_ready, 0);
    rst_n = 1'b1;
    run(50);

    wr(2, MODE_BLINK, 1);
    run(80);

    wr(0, MODE_PWM, 4);
    run(8);
    duty("pwm_duty_4", 4);
    wr(0, MODE_PWM, 0);
    run(8);
    duty("pwm_duty_0", 0);
    wr(0, MODE_PWM, 15);
    run(8);
    duty("pwm_duty_15", 15);

    wr(1, MODE_BREATHE, 0);
    run(320);

    wr(5, MODE_COUNT, 0);
    wr(3, 6, 5);
    wr(7, MODE_ON, 0);
    run(700);

    // Back-to-back writes with valid held high
    acc_cnt = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CHW'(4);
    cfg_if.cfg_mode  = MODE_ON;
    for (int k = 0; k < 8; k++) begin
      if (cfg_if.cfg_ready) acc_cnt++;
      cycle();
      if (m_accept != 0) begin
        cfg_if.cfg_ch   = CHW'($urandom_range(0, N - 1));
        cfg_if.cfg_mode = mode_t'($urandom_range(0, 5));
        cfg_if.cfg_arg  = PB'($urandom_range(0, LMAX));
      end
    end
    cfg_if.cfg_valid = 1'b0;
    check("b2b_accepts", acc_cnt, 4);
    run(5);

    // Blink rewrite whose commit cycle coincides with a tick
    wr(2, MODE_BLINK, 2);
    run(47);
    g = 0;
    while (!(m_presc == TDIV - 2 && m_ready != 0) && g < 30) begin
      cycle();
      g++;
    end
    check("align_found", (g < 30) ? 1 : 0, 1);
    wr(2, MODE_BLINK, 2);
    run(80);

    // Reset asserted mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_led", led, 0);
    check("midrst_ready", cfg_if.cfg_ready, 0);
    check("midrst_tick", tick, 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    run(20);

    // Random configuration traffic
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 99) < 12) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CHW'($urandom_range(0, 7));
        cfg_if.cfg_mode  = mode_t'(($urandom_range(0, 9) == 0) ? $urandom_range(6, 7)
                                                               : $urandom_range(0, 5));
        cfg_if.cfg_arg   = PB'($urandom_range(0, LMAX));
      end else begin
        cfg_if.cfg_valid = 1'b0;
      end
      cycle();
    end
    cfg_if.cfg_valid = 1'b0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised multi-channel LED driver for the Tang Nano 9K status LEDs, replacing the fixed blink/counter logic. It drives N_LED outputs, each independently configured through a valid/ready write port to one of six modes: off, on, blink, static PWM, breathe, or bit of a shared binary counter. All timing is derived from clk_27m through one shared tick prescaler and one free-running PWM counter. It sits between the board-control logic (cfg writer) and the LED pins.

## Interface
- CLOCK_FREQ, 27000000: input clock frequency in Hz.
- TICK_HZ, 1000: tick rate; TICK_DIV = CLOCK_FREQ/TICK_HZ must be ≥ 2, checked at elaboration.
- N_LED, 6: channel count, 1..16; CH_W = max(1, $clog2(N_LED)).
- PWM_BITS, 8: PWM and breathe resolution, 2..12.
- clk_27m  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  engine can accept a write.
- cfg_ch  in  CH_W  target channel.
- cfg_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE, 5 COUNT; 6–7 illegal.
- cfg_arg  in  PWM_BITS  mode argument.
- cfg_err  out  1  one-cycle pulse when an accepted write is rejected.
- tick  out  1  one-cycle pulse every TICK_DIV clocks.
- led  out  N_LED  registered LED drive, active high.

## Operation
- Reset values:
  - led = 0, cfg_ready = 0, cfg_err = 0, tick = 0.
  - All channels mode OFF, arg 0, phase 0, level 0, dir up, blink state 0.
  - Prescaler, PWM counter and shared counter all 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 in the cycle the count equals TICK_DIV-1.
- PWM counter:
  - PWM_BITS wide, increments every clock, wraps at 2^PWM_BITS-1 → 0.
- Shared counter:
  - N_LED wide, increments on tick, wraps.
- Handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - cfg_ready is 1 except in the cycle after an accept, where it is 0 (one commit cycle). Back-to-back writes therefore sustain one write per 2 clocks.
  - cfg_* is sampled only on accept.
- Rejection:
  - cfg_ch ≥ N_LED or cfg_mode ∈ {6,7} → write accepted, no state change, cfg_err = 1 in the following cycle.
- Valid write:
  - Sets the channel's mode and arg.
  - Clears the channel's phase, level, blink state and dir (dir = up).
  - Effective from the next clock.
- Per-channel next output:
  - OFF: 0.
  - ON: 1.
  - BLINK: on each tick, phase++. When phase == arg, phase ← 0 and blink state toggles. Output = blink state, so the half-period is (arg+1) ticks.
  - PWM: output = (pwm_cnt < arg). arg = 0 is always off; the maximum arg gives (2^PWM_BITS-1)/2^PWM_BITS duty.
  - BREATHE:
    - On each tick, phase++. When phase == arg, phase ← 0 and level steps by ±1.
    - Going up at level 2^PWM_BITS-1 → dir flips down and level decrements on that step.
    - Going down at level 0 → dir flips up.
    - Output = (pwm_cnt < level).
  - COUNT: output = shared_cnt[i] for channel i.
- Simultaneous write and tick on the same channel: the write wins and that tick is ignored for that channel. Other channels still see the tick.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). cfg_ready rises on the first clock edge after rst_n deasserts.

## Timing
- led is registered: a mode or arg change is visible on led 2 clocks after the accept edge (commit edge, then output register).
- tick-driven changes (BLINK toggle, breathe step, shared-counter bit) appear on led 1 clock after the tick cycle.
- PWM output follows pwm_cnt with 1 clock of latency.
- cfg_err pulses exactly 1 cycle, aligned with the cfg_ready low cycle.
- Critical path: the arg compare plus the PWM comparator per channel. No multi-cycle paths.

## Structure
- Package led_pattern_pkg:
  - mode constants MODE_OFF..MODE_COUNT.
  - 3-bit mode typedef.
  - function to check mode legality.
- Sub-module led_channel, instantiated N_LED times in a generate loop:
  - Inputs: tick, pwm_cnt, its shared counter bit, write strobe, mode, arg.
  - Holds phase, level, dir and blink state.
  - Outputs its next LED value.
- Prescaler, PWM counter, shared counter, handshake and output register stay in led_pattern_engine.

## Test plan
Bench parameters throughout: CLOCK_FREQ=100, TICK_HZ=10 (TICK_DIV=10), N_LED=6, PWM_BITS=4.
- Reset, then idle 50 clocks:
  - led = 0 and cfg_ready = 0 while in reset; cfg_ready = 1 from the first edge after release.
  - tick pulses at cycles 9, 19, 29, …
- Write ch2 BLINK, arg 1: led[2] toggles every 2 ticks (20 clocks); the first toggle lands 1 clock after the second tick following the write.
- Write ch0 PWM, arg 4:
  - led[0] high for 4 of every 16 clocks.
  - Then arg 0 → constantly 0.
  - Then arg 15 → low for 1 of every 16 clocks.
- Write ch1 BREATHE, arg 0: level rises 0→15 over 15 ticks, falls back to 0 over the next 15 ticks, with duty monotonic between ticks.
- Write ch5 COUNT, then ch3 mode 6, then ch7 ON:
  - led[5] toggles every 32 ticks.
  - Both bad writes give a cfg_err pulse and leave led[3] unchanged.
- Back-to-back cfg_valid held high for 4 writes: cfg_ready pattern is 1,0,1,0,…; exactly 4 accepts in 8 clocks. Run once with a write to a BLINK channel coinciding with tick: phase resets and that tick is ignored.
